// File: rtl/pad_io_pkg.sv
// pad_io_pkg: shared state encoding and counter sizing for the pad serializer
// Contents:
//   pad_state_e - serializer states (idle, lead guard, data shift, trail guard)
//   cnt_width   - bit-counter width able to count any of WIDTH, LEAD, TRAIL periods
package pad_io_pkg;

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL} pad_state_e;

    function automatic int cnt_width(input int width, input int lead, input int trail);
        int m;
        m = width;
        if (lead > m) m = lead;
        if (trail > m) m = trail;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pad_bit_timer.sv
// pad_bit_timer: bit-period down-counter producing a tick on the last cycle of each period
// Ports:
//   clk     - core clock
//   rst     - synchronous active-high reset
//   restart - begin a fresh period from load on the next edge
//   load    - period length minus one
//   tick    - high during the final cycle of the current period
module pad_bit_timer #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [DIV_W-1:0] load,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = cnt == '0;

    // Reloading on tick makes periods back-to-back without a restart pulse.
    always_ff @(posedge clk)
        if (rst)
            cnt <= '0;
        else if (restart || tick)
            cnt <= load;
        else
            cnt <= cnt - 1'b1;

endmodule

// File: rtl/pad_tri_out_ser.sv
// pad_tri_out_ser: serializer driving c2p/c2p_en of a tri-state output pad with lead/trail guards
// Ports:
//   clk, rst  - core clock, synchronous active-high reset
//   div       - bit period minus one, captured on accept
//   in_data   - parallel frame, captured on accept
//   in_valid  - frame offered
//   in_ready  - frame accepted this cycle when in_valid is high
//   c2p       - registered data to the pad
//   c2p_en    - registered pad output enable
//   busy      - a frame is in progress
//   done      - one-cycle pulse after the last bit period of each frame
module pad_tri_out_ser
    import pad_io_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV_W     = 8,
    parameter int LEAD      = 1,
    parameter int TRAIL     = 1,
    parameter bit MSB_FIRST = 1'b0,
    parameter bit IDLE_VAL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             c2p,
    output logic             c2p_en,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH, LEAD, TRAIL);
    localparam logic [CW-1:0] LAST_LEAD  = CW'(LEAD > 0 ? LEAD - 1 : 0);
    localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_TRAIL = CW'(TRAIL > 0 ? TRAIL - 1 : 0);
    localparam pad_state_e FIRST = LEAD > 0 ? S_LEAD : S_SHIFT;
    localparam pad_state_e AFTER = TRAIL > 0 ? S_TRAIL : S_IDLE;

    pad_state_e       state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic             c2p_n, done_n, tick, last_bit, accept;

    // The timer reloads from div_n so a chained accept starts the new
    // frame's first bit period with the freshly captured divider.
    pad_bit_timer #(.DIV_W(DIV_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .restart(accept),
        .load   (div_n),
        .tick   (tick)
    );

    assign busy = state != S_IDLE;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sr_n     = sr;
        div_n    = div_q;
        done_n   = 1'b0;
        last_bit = state == S_SHIFT && tick && cnt == LAST_BIT;
        in_ready = !rst && (state == S_IDLE || last_bit);
        accept   = in_valid && in_ready;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = FIRST;
                    cnt_n   = '0;
                end
            end
            S_LEAD: begin
                if (tick) begin
                    state_n = cnt == LAST_LEAD ? S_SHIFT : S_LEAD;
                    cnt_n   = cnt == LAST_LEAD ? '0 : cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                if (last_bit) begin
                    done_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = accept ? S_SHIFT : AFTER;
                end else if (tick) begin
                    cnt_n = cnt + 1'b1;
                    sr_n  = MSB_FIRST ? sr << 1 : sr >> 1;
                end
            end
            S_TRAIL: begin
                if (tick) begin
                    state_n = cnt == LAST_TRAIL ? S_IDLE : S_TRAIL;
                    cnt_n   = cnt == LAST_TRAIL ? '0 : cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (accept) begin
            sr_n  = in_data;
            div_n = div;
        end
        // TRAIL keeps the last data bit already on c2p.
        c2p_n = state_n == S_SHIFT ? (MSB_FIRST ? sr_n[WIDTH-1] : sr_n[0]) :
                state_n == S_TRAIL ? c2p : IDLE_VAL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            sr     <= '0;
            div_q  <= '0;
            c2p    <= IDLE_VAL;
            c2p_en <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            sr     <= sr_n;
            div_q  <= div_n;
            c2p    <= c2p_n;
            c2p_en <= state_n != S_IDLE;
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_pad_tri_out_ser.sv
// tb_pad_tri_out_ser: scoreboard bench for the pad serializer with a frame-level waveform model
module tb_pad_tri_out_ser;

    localparam int W       = 8;
    localparam int P_LEAD  = 1;
    localparam int P_TRAIL = 1;
    localparam bit P_MSB   = 1'b0;
    localparam bit P_IDLE  = 1'b0;

    typedef struct packed {
        logic en;
        logic d;
        logic dn;
        logic rdy;
    } rec_t;

    localparam rec_t IDLE_REC = '{en: 1'b0, d: P_IDLE, dn: 1'b0, rdy: 1'b1};

    logic clk = 1'b0;
    logic rst;
    logic [7:0] div, in_data;
    logic in_valid, in_ready, c2p, c2p_en, busy, done;
    logic [7:0] m_div, m_data;
    logic m_valid, m_ready, m_c2p, m_en, m_busy, m_done;

    int errors = 0;
    int checks = 0;
    int n_acc = 0;
    bit chk_on = 1'b0;
    rec_t q[$];
    rec_t cur = IDLE_REC;
    rec_t e;

    always #5 clk = ~clk;

    pad_tri_out_ser #(.WIDTH(W), .DIV_W(8), .LEAD(P_LEAD), .TRAIL(P_TRAIL),
                      .MSB_FIRST(P_MSB), .IDLE_VAL(P_IDLE)) dut (
        .clk(clk), .rst(rst), .div(div), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .c2p(c2p), .c2p_en(c2p_en), .busy(busy), .done(done)
    );

    pad_tri_out_ser #(.WIDTH(8), .DIV_W(8), .LEAD(0), .TRAIL(0),
                      .MSB_FIRST(1'b1), .IDLE_VAL(1'b1)) u_msb (
        .clk(clk), .rst(rst), .div(m_div), .in_data(m_data), .in_valid(m_valid),
        .in_ready(m_ready), .c2p(m_c2p), .c2p_en(m_en), .busy(m_busy), .done(m_done)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic bit_of(input logic [7:0] d, input int j);
        return P_MSB ? d[W-1-j] : d[j];
    endfunction

    // Expected pin waveform for a frame, one record per cycle after the accept edge.
    task automatic push_frame(input logic [7:0] d, input int dv, input bit chained);
        int per, lead, nb, k;
        rec_t r;
        per  = dv + 1;
        lead = chained ? 0 : P_LEAD;
        nb   = lead + W + P_TRAIL;
        if (chained) q.delete();
        for (int p = 0; p < nb * per; p++) begin
            k     = p / per;
            r.en  = 1'b1;
            r.d   = k < lead ? P_IDLE : k < lead + W ? bit_of(d, k - lead) : bit_of(d, W - 1);
            r.dn  = (chained && p == 0) || p == (lead + W) * per;
            r.rdy = p == (lead + W) * per - 1;
            q.push_back(r);
        end
        if (P_TRAIL == 0) q.push_back('{en: 1'b0, d: P_IDLE, dn: 1'b1, rdy: 1'b1});
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) q.delete();
        else if (in_valid && cur.rdy) begin
            push_frame(in_data, int'(div), q.size() > 0);
            n_acc++;
        end
        #1;
    endtask

    always @(negedge clk) begin
        e = IDLE_REC;
        if (q.size() > 0) e = q.pop_front();
        cur = e;
        if (chk_on) begin
            chk("c2p_en", c2p_en, e.en);
            chk("c2p", c2p, e.d);
            chk("done", done, e.dn);
            chk("busy", busy, e.en);
            chk("in_ready", in_ready, !rst && e.rdy);
        end
    end

    initial begin
        logic [7:0] md;
        int a0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; div = '0;
        m_valid = 1'b0; m_data = '0; m_div = '0;
        step();
        chk_on = 1'b1;
        step();
        rst = 1'b0;
        repeat (20) step();
        in_data = 8'hA5; div = 8'd0; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_data = 8'h5A; div = 8'd7;
        repeat (15) step();
        in_data = 8'h01; div = 8'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0; div = 8'd0;
        repeat (50) step();
        in_data = 8'hFF; div = 8'd0; in_valid = 1'b1;
        a0 = n_acc;
        step();
        in_data = 8'h00;
        for (int i = 0; i < 200 && n_acc < a0 + 2; i++) step();
        in_valid = 1'b0;
        checks++;
        if (n_acc != a0 + 2) begin
            errors++;
            $display("FAIL chain_accepts got=%0d exp=%0d", n_acc - a0, 2);
        end
        repeat (20) step();
        in_data = 8'hC3; div = 8'd0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();
        in_data = 8'h96; div = 8'd1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (30) step();
        for (int i = 0; i < 2000; i++) begin
            in_valid = $urandom_range(0, 1) == 1;
            in_data  = 8'($urandom);
            div      = 8'($urandom_range(0, 3));
            rst      = $urandom_range(0, 199) == 0;
            step();
        end
        rst = 1'b0; in_valid = 1'b0;
        repeat (60) step();
        @(negedge clk);
        chk("msb_idle_c2p", m_c2p, 1'b1);
        chk("msb_idle_en", m_en, 1'b0);
        chk("msb_idle_ready", m_ready, 1'b1);
        m_data = 8'h80; m_div = 8'd0; m_valid = 1'b1;
        @(posedge clk);
        #1 m_valid = 1'b0; m_data = 8'($urandom); m_div = 8'd5;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("msb80_en", m_en, k <= 8);
            chk("msb80_c2p", m_c2p, k <= 8 ? k == 1 : 1'b1);
            chk("msb80_done", m_done, k == 9);
        end
        md = 8'h35;
        m_data = md; m_div = 8'd1; m_valid = 1'b1;
        @(posedge clk);
        #1 m_valid = 1'b0; m_data = 8'($urandom); m_div = 8'd0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            chk("msb35_en", m_en, k <= 16);
            chk("msb35_c2p", m_c2p, k <= 16 ? md[7 - (k - 1) / 2] : 1'b1);
            chk("msb35_done", m_done, k == 17);
            chk("msb35_busy", m_busy, k <= 16);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
